// File: rtl/adxl362_sample_scheduler.sv
// adxl362_sample_scheduler
//   Derives the ODR sample tick from clk_sys and runs one X/Y/Z(/TEMP)
//   conversion sequence per tick over a shared ADC req/ack port, pushing
//   tagged, sign-extended 16-bit words to the sample FIFO.
//
// Build option:
//   ADXL362_TEMP_SAMPLE_EN  defined   : sequence X,Y,Z,TEMP; tdata updates
//                           undefined : sequence X,Y,Z; tdata tied to 0
//
// Ports:
//   clk_sys, rst_n        clock, asynchronous active-low reset
//   enable, odr[2:0]      measurement mode, output data rate select
//   clr_status            clears data_ready/overrun/fifo_ovf (set wins)
//   odr_tick              one-cycle pulse per ODR period
//   adc_req, adc_ch[1:0]  conversion request and channel
//   adc_ack, adc_data     conversion done, signed 12-bit result
//   fifo_full, fifo_wr,   FIFO handshake and {tag, sign-ext data} word
//   fifo_data[15:0]
//   x/y/z/tdata[11:0]     latest results per channel
//   data_ready, overrun,  sticky status flags
//   fifo_ovf
module adxl362_sample_scheduler #(
  parameter int unsigned BASE_DIV = 250000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  odr,
  input  logic        clr_status,
  output logic        odr_tick,
  output logic        adc_req,
  output logic [1:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [15:0] fifo_data,
  output logic [11:0] xdata,
  output logic [11:0] ydata,
  output logic [11:0] zdata,
  output logic [11:0] tdata,
  output logic        data_ready,
  output logic        overrun,
  output logic        fifo_ovf
);

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

`ifdef ADXL362_TEMP_SAMPLE_EN
  localparam logic [1:0] LAST_CH = 2'd3;
`else
  localparam logic [1:0] LAST_CH = 2'd2;
`endif

  state_t           r_state;
  logic [1:0]       r_ch;
  logic [2:0]       r_odr;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_xdata, r_ydata, r_zdata;
  logic [15:0]      r_fifo_data;
  logic             r_data_ready, r_overrun, r_fifo_ovf;

  logic [2:0]       w_odr_sat;
  logic [CNT_W-1:0] w_div;
  logic             w_odr_chg;
  logic             w_tick;

  // Rates above 400 Hz saturate; each step down doubles the period.
  assign w_odr_sat = (r_odr > 3'd5) ? 3'd5 : r_odr;
  assign w_div     = CNT_W'(BASE_DIV) << (3'd5 - w_odr_sat);
  // The registered odr is about to change: restart the period, no tick.
  assign w_odr_chg = (odr != r_odr);
  assign w_tick    = enable && !w_odr_chg && (r_cnt == w_div - CNT_W'(1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_odr <= '0;
      r_cnt <= '0;
    end else begin
      r_odr <= odr;
      if (!enable || w_odr_chg || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_xdata      <= '0;
      r_ydata      <= '0;
      r_zdata      <= '0;
      r_fifo_data  <= '0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_fifo_ovf   <= 1'b0;
    end else begin
      // Clear first so any set below in the same cycle takes precedence.
      if (clr_status) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
        r_fifo_ovf   <= 1'b0;
      end
      if (w_tick && r_state != IDLE)
        r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_ch         <= '0;
            r_data_ready <= 1'b0;
            r_state      <= REQ;
          end
        end
        REQ: begin
          // Request is held until acked; if disabled meanwhile the
          // result is dropped and the sequence abandoned.
          if (adc_ack) begin
            if (enable) begin
              case (r_ch)
                2'd0: r_xdata <= adc_data;
                2'd1: r_ydata <= adc_data;
                2'd2: r_zdata <= adc_data;
                default: ;
              endcase
              r_fifo_data <= {r_ch, adc_data[11], adc_data[11], adc_data};
              r_state     <= PUSH;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        PUSH: begin
          if (fifo_full)
            r_fifo_ovf <= 1'b1;
          if (r_ch == LAST_CH) begin
            r_data_ready <= 1'b1;
            r_state      <= IDLE;
          end else if (!enable) begin
            r_state <= IDLE;
          end else begin
            r_ch    <= r_ch + 2'd1;
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADXL362_TEMP_SAMPLE_EN
  logic [11:0] r_tdata;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      r_tdata <= '0;
    else if (r_state == REQ && adc_ack && enable && r_ch == 2'd3)
      r_tdata <= adc_data;
  end

  assign tdata = r_tdata;
`else
  assign tdata = '0;
`endif

  assign odr_tick   = w_tick;
  assign adc_req    = (r_state == REQ);
  assign adc_ch     = r_ch;
  assign fifo_wr    = (r_state == PUSH) && !fifo_full;
  assign fifo_data  = r_fifo_data;
  assign xdata      = r_xdata;
  assign ydata      = r_ydata;
  assign zdata      = r_zdata;
  assign data_ready = r_data_ready;
  assign overrun    = r_overrun;
  assign fifo_ovf   = r_fifo_ovf;

endmodule

// File: tb/tb_adxl362_sample_scheduler.sv
module tb_adxl362_sample_scheduler;

  localparam int unsigned BASE_DIV = 10;
`ifdef ADXL362_TEMP_SAMPLE_EN
  localparam int unsigned NCH = 4;
`else
  localparam int unsigned NCH = 3;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  odr;
  logic        clr_status;
  logic        odr_tick;
  logic        adc_req;
  logic [1:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic        fifo_full;
  logic        fifo_wr;
  logic [15:0] fifo_data;
  logic [11:0] xdata, ydata, zdata, tdata;
  logic        data_ready, overrun, fifo_ovf;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  logic [11:0] d3 [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic [15:0] f3 [4] = '{16'h0123, 16'h4456, 16'h8789, 16'hFABC};

  adxl362_sample_scheduler #(.BASE_DIV(BASE_DIV), .CNT_W(24)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable), .odr(odr),
    .clr_status(clr_status), .odr_tick(odr_tick), .adc_req(adc_req),
    .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .xdata(xdata), .ydata(ydata), .zdata(zdata), .tdata(tdata),
    .data_ready(data_ready), .overrun(overrun), .fifo_ovf(fifo_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Returns the number of cycles stepped until odr_tick is seen (max+1 on timeout).
  task automatic wait_tick(input int unsigned max, output int unsigned n);
    n = 0;
    do begin
      step();
      n++;
    end while (!odr_tick && n <= max);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned nwr;
    int unsigned nt;

    rst_n = 1'b0; enable = 1'b0; odr = 3'd4; clr_status = 1'b0;
    adc_ack = 1'b0; adc_data = '0; fifo_full = 1'b0;
    #12;
    chk("rst_ctl", {odr_tick, adc_req, adc_ch, fifo_wr, data_ready, overrun, fifo_ovf}, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_xy", {xdata, ydata}, 0);
    chk("rst_zt", {zdata, tdata}, 0);

    // Divider periods, with the ADC acking immediately.
    rst_n = 1'b1; enable = 1'b1; adc_ack = 1'b1; adc_data = 12'h055;
    wait_tick(100, n);
    wait_tick(100, n); chk("gap_odr4", n, 20);
    wait_tick(100, n); chk("gap_odr4_b", n, 20);
    repeat (7) step();
    odr = 3'd3;
    wait_tick(100, n); chk("restart_odr3", n, 40);
    odr = 3'd0;
    wait_tick(400, n); chk("restart_odr0", n, 320);
    wait_tick(400, n); chk("gap_odr0", n, 320);
    odr = 3'd7;
    wait_tick(100, n); chk("restart_odr7", n, 10);
    wait_tick(100, n); chk("gap_odr7", n, 10);
    odr = 3'd3;
    wait_tick(100, n); chk("restart_odr3_b", n, 40);
    repeat (12) step();
    pulse_clr();
    chk("clr_flags_0", {data_ready, overrun, fifo_ovf}, 0);

    // Immediate ack sequence with boundary data values.
    adc_data = 12'h7FF;
    wait_tick(100, n); chk("t2_tick", odr_tick, 1);
    step(); chk("t2_req_x", {adc_req, fifo_wr, adc_ch, data_ready}, 5'b10000);
    step(); chk("t2_push_x", {adc_req, fifo_wr}, 2'b01);
    chk("t2_fd_x", fifo_data, 16'h07FF); chk("t2_xdata", xdata, 12'h7FF);
    adc_data = 12'h800;
    step(); chk("t2_req_y", {adc_req, fifo_wr, adc_ch}, 4'b1001);
    step(); chk("t2_fd_y", {fifo_wr, fifo_data}, {1'b1, 16'h7800});
    chk("t2_ydata", ydata, 12'h800);
    adc_data = 12'h001;
    step(); chk("t2_req_z", {adc_req, fifo_wr, adc_ch}, 4'b1010);
    step(); chk("t2_fd_z", {fifo_wr, fifo_data}, {1'b1, 16'h8001});
    chk("t2_zdata", zdata, 12'h001); chk("t2_dr_pending", data_ready, 0);
`ifdef ADXL362_TEMP_SAMPLE_EN
    adc_data = 12'h7F0;
    step(); chk("t2_req_t", {adc_req, fifo_wr, adc_ch}, 4'b1011);
    step(); chk("t2_fd_t", {fifo_wr, fifo_data}, {1'b1, 16'hC7F0});
    chk("t2_tdata", tdata, 12'h7F0);
`else
    chk("t2_tdata_tied", tdata, 0);
`endif
    step(); chk("t2_done", {data_ready, adc_req, fifo_wr}, 3'b100);

    // Ack delayed by five cycles on every channel.
    adc_ack = 1'b0;
    wait_tick(100, n); chk("t3_tick", odr_tick, 1);
    for (int c = 0; c < int'(NCH); c++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        chk("t3_req_hold", {adc_req, fifo_wr, adc_ch}, {1'b1, 1'b0, c[1:0]});
        if (k == 4) begin
          adc_ack = 1'b1;
          adc_data = d3[c];
        end
      end
      step();
      chk("t3_push", {adc_req, fifo_wr}, 2'b01);
      chk("t3_fdata", fifo_data, f3[c]);
      adc_ack = 1'b0;
    end
    step(); chk("t3_done", {data_ready, fifo_wr, adc_req}, 3'b100);
    chk("t3_xdata", xdata, 12'h123);

    // FIFO full for a whole sequence.
    fifo_full = 1'b1; adc_ack = 1'b1; adc_data = 12'h321;
    wait_tick(100, n); chk("t4_tick", odr_tick, 1);
    nwr = 0;
    for (int i = 0; i < int'(2 * NCH); i++) begin
      step();
      if (fifo_wr) nwr++;
    end
    chk("t4_no_writes", nwr, 0);
    step();
    chk("t4_flags", {data_ready, overrun, fifo_ovf}, 3'b101);
    chk("t4_xdata", xdata, 12'h321);
    fifo_full = 1'b0;
    pulse_clr();
    chk("t4_clr", {data_ready, overrun, fifo_ovf}, 0);

    // Next tick lands while the ack is withheld.
    adc_ack = 1'b0; adc_data = 12'h0AA;
    wait_tick(100, n); chk("t5_tick", odr_tick, 1);
    repeat (41) step();
    chk("t5_overrun", overrun, 1);
    chk("t5_still_req", {adc_req, adc_ch}, 3'b100);
    adc_ack = 1'b1;
    nwr = 0;
    repeat (30) begin
      step();
      if (fifo_wr) nwr++;
    end
    chk("t5_one_sequence", nwr, NCH);
    chk("t5_xdata", xdata, 12'h0AA);

    // Enable drops while a request is outstanding.
    adc_ack = 1'b0;
    pulse_clr();
    wait_tick(100, n); chk("t6_tick", odr_tick, 1);
    step(); step();
    enable = 1'b0;
    step(); chk("t6_req_held", {adc_req, adc_ch}, 3'b100);
    adc_ack = 1'b1; adc_data = 12'h123;
    step(); chk("t6_abort", {adc_req, fifo_wr}, 2'b00);
    chk("t6_xdata_kept", xdata, 12'h0AA);
    chk("t6_dr_kept", data_ready, 0);
    adc_ack = 1'b0;
    nt = 0; nwr = 0;
    repeat (50) begin
      step();
      if (odr_tick) nt++;
      if (fifo_wr) nwr++;
    end
    chk("t6_disabled_quiet", {nt[7:0], nwr[7:0], 7'd0, adc_req}, 0);
    enable = 1'b1; adc_ack = 1'b1; adc_data = 12'h456;
    wait_tick(100, n); chk("t6_retick", odr_tick, 1);
    step(); chk("t6_restart", {adc_req, adc_ch}, 3'b100);
    step(); chk("t6_push", {fifo_wr, fifo_data}, {1'b1, 16'h0456});

    // Asynchronous reset mid-sequence.
    rst_n = 1'b0;
    #1;
    chk("t7_ctl", {odr_tick, adc_req, adc_ch, fifo_wr, data_ready, overrun, fifo_ovf}, 0);
    chk("t7_fifo_data", fifo_data, 0);
    chk("t7_xy", {xdata, ydata}, 0);
    chk("t7_zt", {zdata, tdata}, 0);
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
